// File: rtl/ifetch_prefetch.sv
// Instruction prefetch buffer: issues sequential word fetches, tags each with
// its address, and queues in-order responses for the decode stage.
module ifetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]     tw_q, tw_d, tr_q, tr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     pending_q, pending_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [INST_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];

    logic          req_acc, rsp_acc, consume, fifo_wr;
    logic [CW+1:0] occupancy;

    assign occupancy = (CW+2)'(count_q) + (CW+2)'(pending_q)
                     + (CW+2)'(discard_q);

    assign mem_req_valid = !rst && !redirect_valid
                        && (occupancy < (CW+2)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;

    assign inst_valid = !rst && (count_q != '0);
    assign inst_data  = inst_valid ? data_q[rptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_q[rptr_q]   : '0;

    always_comb begin
        req_acc = mem_req_valid && mem_req_ready;
        // A response with nothing outstanding is a protocol violation: ignore it.
        rsp_acc = mem_rsp_valid && (pending_q != '0 || discard_q != '0);
        consume = inst_valid && inst_ready;
        fifo_wr = rsp_acc && !redirect_valid && (discard_q == '0);

        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tw_d       = tw_q;
        tr_d       = tr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        discard_d  = discard_q;

        // The tag queue tracks every in-flight request, live or stale.
        if (req_acc) begin
            tw_d       = tw_q + 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (rsp_acc) begin
            tr_d = tr_q + 1'b1;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN;
            rptr_d     = wptr_q;
            count_d    = '0;
            pending_d  = '0;
            discard_d  = discard_q + pending_q - CW'(rsp_acc);
        end else begin
            if (fifo_wr) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (consume) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d   = count_q + CW'(fifo_wr) - CW'(consume);
            pending_d = pending_q + CW'(req_acc) - CW'(fifo_wr);
            if (rsp_acc && discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & ALIGN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tw_q       <= '0;
            tr_q       <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tw_q       <= tw_d;
            tr_q       <= tr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_acc) begin
            tag_q[tw_q] <= fetch_pc_q;
        end
        if (fifo_wr) begin
            data_q[wptr_q] <= mem_rsp_data;
            pc_q[wptr_q]   <= tag_q[tr_q];
        end
    end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries; it is a power of 2 and at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port mem_req_valid, output, 1 bit: fetch request valid.
REQ-008 SHALL have port mem_req_addr, output, ADDR_W bits: word-aligned fetch address.
REQ-009 SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 SHALL have port mem_rsp_valid, input, 1 bit: a response word is present.
REQ-011 SHALL have port mem_rsp_data, input, INST_W bits: the response instruction word.
REQ-012 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-013 SHALL have port redirect_pc, input, ADDR_W bits: the redirect target.
REQ-014 SHALL have port inst_valid, output, 1 bit: the buffer head is valid.
REQ-015 SHALL have port inst_data, output, INST_W bits: the head instruction.
REQ-016 SHALL have port inst_pc, output, ADDR_W bits: the head instruction address.
REQ-017 SHALL have port inst_ready, input, 1 bit: the consumer takes the head.

Function
REQ-018 SHALL accept a request when mem_req_valid && mem_req_ready; a response SHALL be accepted when mem_rsp_valid; a consume SHALL occur when inst_valid && inst_ready.
REQ-019 SHALL assume memory returns responses in order, exactly one per accepted request, with latency of at least 1 cycle.
REQ-020 SHALL keep fetch_pc; after each accepted request, fetch_pc SHALL advance by 4 modulo 2^ADDR_W, wrapping from all-ones-minus-3 to 0.
REQ-021 SHALL drive mem_req_addr = fetch_pc, with bits [1:0] always 0.
REQ-022 SHALL assert mem_req_valid only when !rst && !redirect_valid && (fifo_count + pending + discard) < DEPTH.
REQ-023 SHALL track pending (live in-flight requests) and discard (in-flight requests to be dropped), each log2(DEPTH)+1 bits wide.
REQ-024 SHALL, for a response with discard>0, decrement discard and drop the data; otherwise it SHALL write {data, pc} into the buffer and decrement pending.
REQ-025 SHALL tag each buffer entry with the address its request was issued with; a small in-order tag queue is permitted.
REQ-026 SHALL make buffer writes visible on inst_valid the cycle after the response: registered, no bypass.
REQ-027 SHALL present the buffer as a FIFO; inst_valid = fifo_count != 0; a simultaneous write and consume SHALL keep fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 SHALL, on a redirect cycle, empty the buffer and set fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
REQ-029 SHALL, on a redirect cycle, set discard_next = discard + pending - (response accepted this cycle ? 1 : 0) and pending_next = 0.
REQ-030 SHALL drop any response arriving in the redirect cycle.
REQ-031 SHALL treat a consume coinciding with a redirect as consuming nothing further; the flush wins.
REQ-032 SHALL ignore a response arriving while pending == 0 and discard == 0 (protocol violation); no state change.
REQ-033 SHALL never overflow or underflow fifo_count, pending or discard given a compliant memory.

Reset
REQ-034 SHALL, while rst is high at a clock edge, set fetch_pc=RESET_PC, fifo_count=0, pending=0, discard=0 and both pointers to 0.
REQ-035 SHALL hold mem_req_valid=0, inst_valid=0, inst_data=0 and inst_pc=0 during reset.
REQ-036 SHALL assert mem_req_valid with addr=RESET_PC in the first cycle after rst falls.
REQ-037 SHALL, when reset is asserted mid-operation, drop all in-flight and buffered state; responses arriving after reset to requests issued before it are outside the contract.

Verification
REQ-038 SHALL verify: reset release, ready=1, 1-cycle memory, inst_ready=1 -> requests 0x0,0x4,0x8,...; the first inst_valid comes 2 cycles after the first request, with inst_pc=0x0 and in-order data.
REQ-039 SHALL verify: inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid stays 0; inst_valid stays 1 with inst_pc=0x0.
REQ-040 SHALL verify: redirect to 0x103 with 3 in flight -> next request addr=0x100; the 3 stale responses are dropped; the first inst_pc seen is 0x100.
REQ-041 SHALL verify: redirect in the same cycle as a response -> that response is dropped; discard equals the prior pending-1.
REQ-042 SHALL verify: fetch_pc=0xFFFFFFFC, request accepted -> the next request addr=0x00000000.
REQ-043 SHALL verify: rst asserted with a full buffer -> next cycle inst_valid=0, mem_req_valid=0; after release the request addr=RESET_PC.
